display_mux_n: RTL and testbench

- Parametrised N-digit multiplexed 7-segment driver. Successor to the fixed 4-digit HEX display driver.
- Adds:
  - configurable digit count and scan rate
  - frame-coherent data loading through a shadow register
  - leading-zero and per-digit blanking
  - per-digit decimal-point mask
  - PWM brightness
  - anti-ghosting dead time
- Sits between datapath status registers and board anode/segment pins. Also provides the 1 ms system tick ce1ms.

---
 rtl/display_mux_n_pkg.sv | 17 +
 rtl/display_mux_n_lz_mask_gen.sv | 30 +++
 rtl/display_mux_n.sv | 143 ++++++++++++++
 tb/tb_display_mux_n.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_mux_n_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// blank pattern and the HEX-to-segment decode table (gfedcba, active-low).
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the segment pattern for nibble n; entry 15 is written first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/display_mux_n_lz_mask_gen.sv
// Per-digit dark mask: leading-zero suppression ORed with the live blank mask.
// Digit 0 is never leading-zero blanked, so only the upper nibbles are needed.
module lz_mask_gen #(
  parameter int NDIG = 4
) (
  input  logic [4*(NDIG-1)-1:0] i_nib_upper,
  input  logic                  i_lz_blank,
  input  logic [NDIG-1:0]       i_blank_mask,
  output logic [NDIG-1:0]       o_dark
);

  logic [NDIG-1:1] w_zero;
  logic [NDIG-1:1] w_lz_run;

  assign o_dark[0] = i_blank_mask[0];

  // w_lz_run[i] is set when nibble i and every higher nibble are zero.
  generate
    for (genvar gi = 1; gi < NDIG; gi++) begin : g_dig
      assign w_zero[gi] = (i_nib_upper[4*(gi-1) +: 4] == 4'h0);
      if (gi == NDIG-1) begin : g_top
        assign w_lz_run[gi] = w_zero[gi];
      end else begin : g_mid
        assign w_lz_run[gi] = w_zero[gi] & w_lz_run[gi+1];
      end
      assign o_dark[gi] = i_blank_mask[gi] | (i_lz_blank & w_lz_run[gi]);
    end
  endgenerate

endmodule

// File: rtl/display_mux_n.sv
// N-digit multiplexed 7-segment driver with frame-coherent shadow loading,
// blanking, decimal points, PWM brightness, dead time and a scan-rate tick.
module display_mux_n
  import display_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int FCLK_KHZ  = 50000,
  parameter int FSCAN_KHZ = 1,
  parameter int BRIGHT_W  = 3,
  parameter int DEAD_CLKS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*NDIG-1:0]   dat,
  input  logic                load,
  input  logic [NDIG-1:0]     dp_mask,
  input  logic [NDIG-1:0]     blank_mask,
  input  logic                lz_blank,
  input  logic [BRIGHT_W-1:0] bright,
  output logic [NDIG-1:0]     AN,
  output logic [6:0]          seg,
  output logic                seg_P,
  output logic                ce1ms,
  output logic                frame_done
);

  localparam int DIV   = FCLK_KHZ / FSCAN_KHZ;
  localparam int CB_W  = $clog2(DIV + 1);
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CB_W-1:0]  CB_ONE   = CB_W'(1);
  localparam logic [CB_W-1:0]  CB_DIV   = CB_W'(DIV);
  localparam logic [CB_W-1:0]  CB_DEAD  = CB_W'(DEAD_CLKS);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NDIG - 1);

  logic [CB_W-1:0]     r_cb;
  logic [DIG_W-1:0]    r_cb_dig;
  logic [BRIGHT_W-1:0] r_pwm_cnt;
  logic                r_ce1ms;

  logic [4*NDIG-1:0]   r_disp;
  logic [NDIG-1:0]     r_dp;
  logic [4*NDIG-1:0]   r_shadow;
  logic [NDIG-1:0]     r_shadow_dp;
  logic                r_pend;
  logic                r_frame_done;

  logic [NDIG-1:0]     r_an;
  logic [6:0]          r_seg;
  logic                r_seg_p;

  logic                w_ce;
  logic                w_boundary;
  logic [NDIG-1:0]     w_dark;
  logic [3:0]          w_nib;
  logic                w_on;

  assign w_ce       = (r_cb == CB_DIV);
  assign w_boundary = w_ce && (r_cb_dig == DIG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cb      <= CB_ONE;
      r_cb_dig  <= '0;
      r_pwm_cnt <= '0;
      r_ce1ms   <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_cb      <= w_ce ? CB_ONE : r_cb + CB_ONE;
      r_ce1ms   <= w_ce;
      if (w_ce) begin
        r_cb_dig <= (r_cb_dig == DIG_LAST) ? '0 : r_cb_dig + 1'b1;
      end
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp       <= '0;
      r_dp         <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_pend       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_boundary && load) begin
        r_disp       <= dat;
        r_dp         <= dp_mask;
        r_shadow     <= dat;
        r_shadow_dp  <= dp_mask;
        r_pend       <= 1'b0;
        r_frame_done <= 1'b1;
      end else if (w_boundary && r_pend) begin
        r_disp       <= r_shadow;
        r_dp         <= r_shadow_dp;
        r_pend       <= 1'b0;
        r_frame_done <= 1'b1;
      end else if (load) begin
        r_shadow    <= dat;
        r_shadow_dp <= dp_mask;
        r_pend      <= 1'b1;
      end
    end
  end

  lz_mask_gen #(
    .NDIG(NDIG)
  ) u_lz_mask_gen (
    .i_nib_upper (r_disp[4*NDIG-1:4]),
    .i_lz_blank  (lz_blank),
    .i_blank_mask(blank_mask),
    .o_dark      (w_dark)
  );

  assign w_nib = r_disp[4*r_cb_dig +: 4];
  assign w_on  = (r_cb > CB_DEAD) && (r_pwm_cnt <= bright) && !w_dark[r_cb_dig];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
      r_seg_p <= 1'b1;
    end else begin
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
      r_seg_p <= 1'b1;
      if (w_on) begin
        r_an[r_cb_dig] <= 1'b0;
        r_seg          <= hex2seg(w_nib);
        r_seg_p        <= ~r_dp[r_cb_dig];
      end
    end
  end

  assign AN         = r_an;
  assign seg        = r_seg;
  assign seg_P      = r_seg_p;
  assign ce1ms      = r_ce1ms;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_mux_n.sv
// Self-checking bench for display_mux_n (4 digits, DIV=8, dead time 2, 2-bit brightness).
module tb_display_mux_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dat = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic        lz_blank = 1'b0;
  logic [1:0]  bright = 2'd3;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_p;
  logic        ce1ms;
  logic        frame_done;

  display_mux_n #(
    .NDIG(4), .FCLK_KHZ(8), .FSCAN_KHZ(1), .BRIGHT_W(2), .DEAD_CLKS(2)
  ) dut (
    .clk(clk), .rst(rst), .dat(dat), .load(load), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .lz_blank(lz_blank), .bright(bright),
    .AN(an), .seg(seg), .seg_P(seg_p), .ce1ms(ce1ms), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       p;
    logic       ce;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state: n counts clocks since reset release.
  int          n = 0;
  logic [15:0] m_disp = 16'h0, m_sh = 16'h0;
  logic [3:0]  m_dp = 4'h0, m_shdp = 4'h0;
  logic        m_pend = 1'b0;

  int          fd_cnt = 0, ce_cnt = 0, low_cnt = 0;
  logic [3:0]  cap_lit = 4'h0, cap_dp = 4'h0;
  logic [6:0]  cap_seg [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_dark(input int d);
    return blank_mask[d] | (lz_blank && d != 0 && ((m_disp >> (4*d)) == 16'h0));
  endfunction

  task automatic clear_cap();
    cap_lit = 4'h0;
    cap_dp  = 4'h0;
    for (int d = 0; d < 4; d++) cap_seg[d] = 7'h7F;
  endtask

  task automatic tick();
    exp_t e;
    int cb, dig, pwm, nib;
    logic bnd;
    e = '{an: 4'hF, seg: 7'h7F, p: 1'b1, ce: 1'b0, fd: 1'b0};
    bnd = 1'b0;
    if (!rst) begin
      cb  = (n % 8) + 1;
      dig = (n / 8) % 4;
      pwm = n % 4;
      bnd = (cb == 8) && (dig == 3);
      nib = int'((m_disp >> (4*dig)) & 16'hF);
      if (cb > 2 && pwm <= int'(bright) && !m_dark(dig)) begin
        e.an[dig] = 1'b0;
        e.seg     = HEX_REF[nib];
        e.p       = ~m_dp[dig];
      end
      e.ce = (cb == 8);
      e.fd = bnd && (m_pend || load);
    end
    sb.push_back(e);
    if (rst) begin
      n = 0; m_disp = 16'h0; m_dp = 4'h0; m_sh = 16'h0; m_shdp = 4'h0; m_pend = 1'b0;
    end else begin
      if (bnd && load) begin
        m_disp = dat; m_dp = dp_mask; m_pend = 1'b0;
      end else if (bnd && m_pend) begin
        m_disp = m_sh; m_dp = m_shdp; m_pend = 1'b0;
      end else if (load) begin
        m_sh = dat; m_shdp = dp_mask; m_pend = 1'b1;
      end
      n++;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("AN", 32'(an), 32'(e.an));
    chk("seg", 32'(seg), 32'(e.seg));
    chk("seg_P", 32'(seg_p), 32'(e.p));
    chk("ce1ms", 32'(ce1ms), 32'(e.ce));
    chk("frame_done", 32'(frame_done), 32'(e.fd));
    fd_cnt += int'(frame_done);
    ce_cnt += int'(ce1ms);
    if (an !== 4'hF) low_cnt++;
    for (int d = 0; d < 4; d++) begin
      if (an[d] === 1'b0) begin
        cap_lit[d] = 1'b1;
        cap_seg[d] = seg;
        if (seg_p === 1'b0) cap_dp[d] = 1'b1;
      end
    end
    load = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 40 && (n % 32) != ph; i++) tick();
  endtask

  initial begin
    clear_cap();

    // Reset held for three clocks, then scan of "0000".
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    ce_cnt = 0;
    clear_cap();
    run(32);
    chk("ce_per_frame", 32'(ce_cnt), 32'd4);
    chk("lit_after_reset", 32'(cap_lit), 32'hF);
    chk("d3_zero", 32'(cap_seg[3]), 32'h40);

    // Two loads mid-frame: only the last reaches the display, at the boundary.
    wait_phase(12);
    fd_cnt = 0;
    dat = 16'h1234; load = 1'b1; tick();
    tick();
    dat = 16'hABCD; load = 1'b1; tick();
    clear_cap();
    wait_phase(0);
    chk("old_d3_kept", 32'(cap_seg[3]), 32'h40);
    clear_cap();
    run(32);
    chk("one_frame_done", 32'(fd_cnt), 32'd1);
    chk("abcd_d0", 32'(cap_seg[0]), 32'h21);
    chk("abcd_d1", 32'(cap_seg[1]), 32'h46);
    chk("abcd_d2", 32'(cap_seg[2]), 32'h03);
    chk("abcd_d3", 32'(cap_seg[3]), 32'h08);

    // Leading-zero suppression.
    lz_blank = 1'b1;
    dat = 16'h0050; load = 1'b1; tick();
    wait_phase(0);
    clear_cap();
    run(32);
    chk("lz_lit_0050", 32'(cap_lit), 32'h3);
    chk("lz_d1_five", 32'(cap_seg[1]), 32'h12);
    chk("lz_d0_zero", 32'(cap_seg[0]), 32'h40);
    dat = 16'h0000; load = 1'b1; tick();
    wait_phase(0);
    clear_cap();
    run(32);
    chk("lz_lit_0000", 32'(cap_lit), 32'h1);

    // Brightness and dead time over one full frame each.
    lz_blank = 1'b0;
    bright = 2'd0;
    low_cnt = 0;
    run(32);
    chk("dim_on_cycles", 32'(low_cnt), 32'd4);
    bright = 2'd3;
    low_cnt = 0;
    run(32);
    chk("full_on_cycles", 32'(low_cnt), 32'd24);

    // Decimal point on digit 2, digit 0 forced dark.
    dp_mask = 4'b0100; dat = 16'h0000; load = 1'b1; tick();
    blank_mask = 4'b0001;
    wait_phase(0);
    clear_cap();
    run(32);
    chk("dp_digits", 32'(cap_dp), 32'h4);
    chk("blank_lit", 32'(cap_lit), 32'hE);

    // Reset before the boundary discards the pending load.
    wait_phase(4);
    dat = 16'h9999; load = 1'b1; tick();
    run(3);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    blank_mask = 4'h0;
    fd_cnt = 0;
    clear_cap();
    run(64);
    chk("rst_no_frame_done", 32'(fd_cnt), 32'd0);
    chk("rst_lit", 32'(cap_lit), 32'hF);
    chk("rst_d3_zero", 32'(cap_seg[3]), 32'h40);
    chk("rst_dp_cleared", 32'(cap_dp), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
